rs_seg_pipe_alu: RTL and testbench

//  Pipelined, parametrised add/subtract ALU. Splits a WIDTH-bit addition into SEG-bit carry-chain

---
 rtl/rs_seg_pipe_alu_if.sv | 34 +++
 rtl/rs_seg_pipe_alu.sv | 143 ++++++++++++++
 tb/tb_rs_seg_pipe_alu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rs_seg_pipe_alu_if.sv
// ----------------------------------------------------------------------------
// rs_seg_pipe_alu_if
// Stream bundle for the segmented pipelined add/subtract ALU.
//   in_valid/in_ready  : operand beat handshake (a, b, ci, bi travel with it)
//   out_valid/out_ready: result beat handshake (y, x, co, ov travel with it)
// master : operand source and result consumer
// slave  : the ALU
// ----------------------------------------------------------------------------
interface rs_seg_pipe_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             bi;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] x;
    logic             co;
    logic             ov;

    modport master (
        output in_valid, a, b, ci, bi, out_ready,
        input  in_ready, out_valid, y, x, co, ov
    );

    modport slave (
        input  in_valid, a, b, ci, bi, out_ready,
        output in_ready, out_valid, y, x, co, ov
    );
endinterface

// File: rtl/rs_seg_pipe_alu.sv
// ----------------------------------------------------------------------------
// rs_seg_pipe_alu
// Pipelined add/subtract ALU. A WIDTH-bit addition is cut into SEG-bit carry
// chain segments, one register stage per segment. Stage k adds segment k with
// the registered carry of stage k-1 (stage 0 uses ci). Unconsumed operand bits
// ride forward with the beat; finished result bits accumulate so y, x, co and
// ov leave together from the last stage.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high; empties the pipeline
//   bus  : slave side of rs_seg_pipe_alu_if
//          y = a + (bi ? ~b : b) + ci, x = a ^ (bi ? ~b : b),
//          co = carry out of MSB, ov = carry into MSB ^ co
// The whole pipeline stalls while a result is offered and not taken.
// ----------------------------------------------------------------------------
module rs_seg_pipe_alu #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    rs_seg_pipe_alu_if.slave bus
);
    localparam int NSEG = (WIDTH + SEG - 1) / SEG;
    localparam int LSEG = WIDTH - (NSEG - 1) * SEG;

    logic adv_s;
    logic out_valid_s;

    // Pipeline moves when the output slot is empty or being drained this cycle.
    always_comb begin
        adv_s = !out_valid_s || bus.out_ready;
    end

    assign bus.in_ready = adv_s;

    for (genvar k = 0; k < NSEG; k++) begin : stg
        localparam int W   = (k == NSEG - 1) ? LSEG : SEG;  // bits added here
        localparam int LO  = k * SEG;                        // first result bit
        localparam int REM = WIDTH - LO - W;                 // operand bits left after here

        // Operand bits still unconsumed on entry: bit 0 is result bit LO.
        logic [WIDTH-LO-1:0] a_all_s;
        logic [WIDTH-LO-1:0] b_all_s;
        logic                vld_in_s;
        logic                c_in_s;
        logic [WIDTH-1:0]    x_in_s;
        logic [LO+W-1:0]     y_nxt_s;
        logic [W:0]          sum_s;

        logic                vld_r;
        logic                c_r;
        logic [WIDTH-1:0]    x_r;
        logic [LO+W-1:0]     y_r;

        if (k == 0) begin : g_src
            // First stage takes the beat straight from the input port.
            always_comb begin
                a_all_s  = bus.a;
                b_all_s  = bus.bi ? ~bus.b : bus.b;
                vld_in_s = bus.in_valid;
                c_in_s   = bus.ci;
                x_in_s   = bus.a ^ b_all_s;
                y_nxt_s  = sum_s[W-1:0];
            end
        end else begin : g_src
            // Later stages take the beat from the previous stage register.
            always_comb begin
                a_all_s  = stg[k-1].g_op.a_r;
                b_all_s  = stg[k-1].g_op.b_r;
                vld_in_s = stg[k-1].vld_r;
                c_in_s   = stg[k-1].c_r;
                x_in_s   = stg[k-1].x_r;
                y_nxt_s  = {sum_s[W-1:0], stg[k-1].y_r};
            end
        end

        // Segment carry chain; the extra MSB is the carry into the next segment.
        always_comb begin
            sum_s = {1'b0, a_all_s[W-1:0]} + {1'b0, b_all_s[W-1:0]} + {{W{1'b0}}, c_in_s};
        end

        // Stage register: valid, carry, propagate vector and partial sum advance together.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r <= 1'b0;
                c_r   <= 1'b0;
                x_r   <= {WIDTH{1'b0}};
                y_r   <= {(LO + W){1'b0}};
            end else if (adv_s) begin
                vld_r <= vld_in_s;
                c_r   <= sum_s[W];
                x_r   <= x_in_s;
                y_r   <= y_nxt_s;
            end
        end

        if (k < NSEG - 1) begin : g_op
            logic [REM-1:0] a_r;
            logic [REM-1:0] b_r;

            // Carry the not-yet-added operand bits forward with the beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= {REM{1'b0}};
                    b_r <= {REM{1'b0}};
                end else if (adv_s) begin
                    a_r <= a_all_s[WIDTH-LO-1:W];
                    b_r <= b_all_s[WIDTH-LO-1:W];
                end
            end
        end

        if (k == NSEG - 1) begin : g_ov
            logic cm_s;
            logic ov_r;

            // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
            always_comb begin
                cm_s = sum_s[W-1] ^ a_all_s[W-1] ^ b_all_s[W-1];
            end

            // Signed overflow register, aligned with the final result stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ov_r <= 1'b0;
                end else if (adv_s) begin
                    ov_r <= cm_s ^ sum_s[W];
                end
            end
        end
    end

    // Output beat comes straight from the last stage registers.
    always_comb begin
        out_valid_s = stg[NSEG-1].vld_r;
    end

    assign bus.out_valid = out_valid_s;
    assign bus.y         = stg[NSEG-1].y_r;
    assign bus.x         = stg[NSEG-1].x_r;
    assign bus.co        = stg[NSEG-1].c_r;
    assign bus.ov        = stg[NSEG-1].g_ov.ov_r;
endmodule

// File: tb/tb_rs_seg_pipe_alu.sv
// ----------------------------------------------------------------------------
// tb_rs_seg_pipe_alu
// Directed bench for rs_seg_pipe_alu at WIDTH/SEG = 32/8, 20/8 and 8/8.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_rs_seg_pipe_alu;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rs_seg_pipe_alu_if #(.WIDTH(32)) if32 ();
    rs_seg_pipe_alu_if #(.WIDTH(20)) if20 ();
    rs_seg_pipe_alu_if #(.WIDTH(8))  if8 ();

    rs_seg_pipe_alu #(.WIDTH(32), .SEG(8)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    rs_seg_pipe_alu #(.WIDTH(20), .SEG(8)) dut20 (.clk(clk), .rst(rst), .bus(if20.slave));
    rs_seg_pipe_alu #(.WIDTH(8),  .SEG(8)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 = 32-bit DUT, 1 = 20-bit DUT, 2 = 8-bit DUT
    task automatic set_in(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic bi);
        if32.in_valid = v && (sel == 0);
        if32.a = a;          if32.b = b;          if32.ci = ci; if32.bi = bi;
        if20.in_valid = v && (sel == 1);
        if20.a = a[19:0];    if20.b = b[19:0];    if20.ci = ci; if20.bi = bi;
        if8.in_valid  = v && (sel == 2);
        if8.a  = a[7:0];     if8.b  = b[7:0];     if8.ci  = ci; if8.bi  = bi;
    endtask

    task automatic set_ready(input logic r);
        if32.out_ready = r;
        if20.out_ready = r;
        if8.out_ready  = r;
    endtask

    task automatic get_out(input int sel, output logic v, output logic [31:0] y, output logic [31:0] x,
                           output logic co, output logic ov);
        case (sel)
            0: begin v = if32.out_valid; y = if32.y; x = if32.x; co = if32.co; ov = if32.ov; end
            1: begin v = if20.out_valid; y = {12'h000, if20.y}; x = {12'h000, if20.x}; co = if20.co; ov = if20.ov; end
            default: begin v = if8.out_valid; y = {24'h000000, if8.y}; x = {24'h000000, if8.x}; co = if8.co; ov = if8.ov; end
        endcase
    endtask

    // One isolated beat: check latency and all result fields.
    task automatic beat(input string tag, input int sel, input int lat,
                        input logic [31:0] a, input logic [31:0] b, input logic ci, input logic bi,
                        input logic [31:0] ey, input logic [31:0] ex, input logic eco, input logic eov);
        int n;
        logic v, co, ov;
        logic [31:0] y, x;
        @(negedge clk);
        set_in(sel, 1'b1, a, b, ci, bi);
        @(negedge clk);
        set_in(sel, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 1;
        get_out(sel, v, y, x, co, ov);
        while (!v && n < 10) begin
            @(negedge clk);
            n++;
            get_out(sel, v, y, x, co, ov);
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_x"}, x, ex);
        chk({tag, "_co"}, co, eco);
        chk({tag, "_ov"}, ov, eov);
    endtask

    initial begin
        logic [65:0] q[$];
        logic [65:0] held;
        logic [31:0] ra, rb, beff, my;
        logic        rci, rbi, mco, mov, hold;
        int          sent, rcvd, cyc, extra;

        // ---------------- reset ----------------
        rst = 1'b1;
        set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        set_ready(1'b1);
        repeat (3) @(negedge clk);
        chk("rst_out_valid", if32.out_valid, 1'b0);
        chk("rst_y", if32.y, 32'h0);
        chk("rst_x", if32.x, 32'h0);
        chk("rst_co_ov", {if32.co, if32.ov}, 2'b00);
        chk("rst_in_ready", if32.in_ready, 1'b1);
        rst = 1'b0;

        // ---------------- directed beats ----------------
        beat("wrap32",  0, 4, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
        beat("sub5_7",  0, 4, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0);
        beat("sub7_5",  0, 4, 32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 32'hFFFFFFFD, 1'b1, 1'b0);
        beat("ovfpos",  0, 4, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFE, 1'b0, 1'b1);
        beat("ovfneg",  0, 4, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b1);
        beat("segcy",   0, 4, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 32'h000000FE, 1'b0, 1'b0);
        beat("wrap20",  1, 3, 32'h000FFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 32'h000FFFFE, 1'b1, 1'b0);
        beat("ovf20",   1, 3, 32'h00080000, 32'h00080000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b1);
        beat("ovf8",    2, 1, 32'h0000007F, 32'h00000001, 1'b0, 1'b0, 32'h00000080, 32'h0000007E, 1'b0, 1'b1);
        beat("sub8",    2, 1, 32'h00000010, 32'h00000020, 1'b1, 1'b1, 32'h000000F0, 32'h000000CF, 1'b0, 1'b0);

        // ---------------- stall / hold / simultaneous drain+fill ----------------
        @(negedge clk); set_ready(1'b0); set_in(0, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0);
        @(negedge clk); set_in(0, 1'b1, 32'hA, 32'h14, 1'b0, 1'b0);
        @(negedge clk); set_in(0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        @(negedge clk); set_in(0, 1'b1, 32'h100, 32'h1, 1'b1, 1'b1);
        @(negedge clk); set_in(0, 1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b0);
        #1;
        chk("stall_valid", if32.out_valid, 1'b1);
        chk("stall_in_ready", if32.in_ready, 1'b0);
        chk("stall_y0", if32.y, 32'h3);
        repeat (2) begin
            @(negedge clk);
            chk("stall_hold_y", if32.y, 32'h3);
            chk("stall_hold_rdy", if32.in_ready, 1'b0);
        end
        set_ready(1'b1);
        #1;
        chk("drainfill_rdy", if32.in_ready, 1'b1);
        @(negedge clk); set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("drain_b", {if32.out_valid, if32.y}, {1'b1, 32'h0000001E});
        @(negedge clk);
        chk("drain_c", {if32.out_valid, if32.co, if32.y}, {1'b1, 1'b1, 32'hFFFFFFFE});
        @(negedge clk);
        chk("drain_d", {if32.out_valid, if32.y}, {1'b1, 32'h000000FF});
        @(negedge clk);
        chk("drain_e", {if32.out_valid, if32.y}, {1'b1, 32'h23456789});
        @(negedge clk);
        chk("drain_empty", if32.out_valid, 1'b0);

        // ---------------- random stream with random backpressure ----------------
        sent = 0; rcvd = 0; cyc = 0; hold = 1'b0; held = 66'h0;
        while (rcvd < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                chk("hold_valid", if32.out_valid, 1'b1);
                chk("hold_data", {if32.co, if32.ov, if32.y, if32.x}, held);
            end
            if32.out_ready = ($urandom_range(0, 1) == 1);
            if (sent < 100 && $urandom_range(0, 3) != 0) begin
                ra = $urandom; rb = $urandom;
                rci = ($urandom_range(0, 1) == 1); rbi = ($urandom_range(0, 1) == 1);
                set_in(0, 1'b1, ra, rb, rci, rbi);
            end else begin
                set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            end
            #1;
            if (if32.in_valid && if32.in_ready) begin
                beff = if32.bi ? ~if32.b : if32.b;
                {mco, my} = {1'b0, if32.a} + {1'b0, beff} + {32'h0, if32.ci};
                mov = (my[31] ^ if32.a[31] ^ beff[31]) ^ mco;
                q.push_back({mco, mov, my, if32.a ^ beff});
                sent++;
            end
            if (if32.out_valid) begin
                if (if32.out_ready) begin
                    chk("stream_nonempty", q.size() != 0, 1'b1);
                    if (q.size() != 0) begin
                        chk("stream_data", {if32.co, if32.ov, if32.y, if32.x}, q.pop_front());
                    end
                    rcvd++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    held = {if32.co, if32.ov, if32.y, if32.x};
                end
            end else begin
                hold = 1'b0;
            end
        end
        chk("stream_rcvd", rcvd, 100);
        set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        set_ready(1'b1);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (if32.out_valid) extra++;
        end
        chk("stream_no_dup", extra, 0);
        chk("stream_queue_empty", q.size(), 0);

        // ---------------- reset with beats in flight ----------------
        @(negedge clk); set_in(0, 1'b1, 32'h1, 32'h1, 1'b0, 1'b0);
        @(negedge clk); set_in(0, 1'b1, 32'h2, 32'h2, 1'b0, 1'b0);
        @(negedge clk); set_in(0, 1'b1, 32'h3, 32'h3, 1'b0, 1'b0);
        @(negedge clk); set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", if32.out_valid, 1'b0);
        chk("midrst_y", if32.y, 32'h0);
        chk("midrst_in_ready", if32.in_ready, 1'b1);
        rst = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (if32.out_valid) extra++;
        end
        chk("midrst_no_stale", extra, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
